// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master AXI4 read-channel arbiter in front of one shared
//               read slave. The shared slave is granted round-robin, one whole
//               burst at a time. The AR request is registered and forwarded.
//               R beats go back to the granted master until RLAST. A beat
//               counter checks where RLAST lands and raises a sticky
//               protocol-error flag when it is misplaced.
// Ports       : S_AXI_ACLK / S_AXI_ARESET    - clock, async active-high reset
//               S0_AXI_AR* / S1_AXI_AR*      - upstream read-address channels
//               S0_AXI_R*  / S1_AXI_R*       - upstream read-data channels
//               M_AXI_AR*  / M_AXI_R*        - shared downstream slave
//               o_grant                      - current / most recent grant
//               o_busy                       - arbiter not idle
//               o_proto_err                  - sticky RLAST placement error
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int C_AXI_ID_WIDTH   = 2,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    // Master 0
    input  logic                        S0_AXI_ARVALID,
    output logic                        S0_AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S0_AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S0_AXI_ARADDR,
    input  logic [7:0]                  S0_AXI_ARLEN,
    output logic                        S0_AXI_RVALID,
    input  logic                        S0_AXI_RREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S0_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S0_AXI_RDATA,
    output logic [1:0]                  S0_AXI_RRESP,
    output logic                        S0_AXI_RLAST,
    // Master 1
    input  logic                        S1_AXI_ARVALID,
    output logic                        S1_AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S1_AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S1_AXI_ARADDR,
    input  logic [7:0]                  S1_AXI_ARLEN,
    output logic                        S1_AXI_RVALID,
    input  logic                        S1_AXI_RREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S1_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S1_AXI_RDATA,
    output logic [1:0]                  S1_AXI_RRESP,
    output logic                        S1_AXI_RLAST,
    // Shared slave
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    // Status
    output logic                        o_grant,
    output logic                        o_busy,
    output logic                        o_proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic                          r_grant;
    logic                          r_arvalid;
    logic [C_AXI_ID_WIDTH-1:0]     r_arid;
    logic [C_AXI_ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]                    r_arlen;
    logic [8:0]                    r_cnt;
    logic                          r_err;

    logic                          w_chosen;
    logic                          w_ar_hs;
    logic                          w_beat;
    logic                          w_s0_arready;
    logic                          w_s1_arready;
    logic                          w_s0_rvalid;
    logic                          w_s1_rvalid;
    logic                          w_m_rready;
    logic [C_AXI_ID_WIDTH-1:0]     w_sel_id;
    logic [C_AXI_ADDR_WIDTH-1:0]   w_sel_addr;
    logic [7:0]                    w_sel_len;
    logic                          w_last_early;
    logic                          w_last_missing;

    // A lone requester wins outright; with both requesting the master that
    // did not hold the last grant wins.
    assign w_chosen   = (S0_AXI_ARVALID && S1_AXI_ARVALID) ? ~r_grant : S1_AXI_ARVALID;
    assign w_sel_id   = w_chosen ? S1_AXI_ARID   : S0_AXI_ARID;
    assign w_sel_addr = w_chosen ? S1_AXI_ARADDR : S0_AXI_ARADDR;
    assign w_sel_len  = w_chosen ? S1_AXI_ARLEN  : S0_AXI_ARLEN;

    assign w_beat = M_AXI_RVALID && w_m_rready;

    // Count is 9 bits so that the beat after ARLEN=255 never aliases to 0.
    assign w_last_early   = M_AXI_RLAST  && (r_cnt != {1'b0, r_arlen});
    assign w_last_missing = !M_AXI_RLAST && (r_cnt == {1'b0, r_arlen});

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ar_hs      = 1'b0;
        w_s0_arready = 1'b0;
        w_s1_arready = 1'b0;
        w_s0_rvalid  = 1'b0;
        w_s1_rvalid  = 1'b0;
        w_m_rready   = 1'b0;
        // Handshake outputs are forced low while reset is held so nothing
        // is accepted or forwarded during an abandoned burst.
        if (!S_AXI_ARESET) begin
            case (r_state)
                S_IDLE: begin
                    w_s0_arready = ~w_chosen;
                    w_s1_arready = w_chosen;
                    w_ar_hs      = w_chosen ? S1_AXI_ARVALID : S0_AXI_ARVALID;
                    if (w_ar_hs) begin
                        w_state_nxt = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_s0_rvalid = M_AXI_RVALID && !r_grant;
                    w_s1_rvalid = M_AXI_RVALID &&  r_grant;
                    w_m_rready  = r_grant ? S1_AXI_RREADY : S0_AXI_RREADY;
                    if (M_AXI_RVALID && w_m_rready && M_AXI_RLAST) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_grant   <= 1'b1;  // master 0 wins the first contested round
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arid    <= w_sel_id;
                r_araddr  <= w_sel_addr;
                r_arlen   <= w_sel_len;
                r_grant   <= w_chosen;
                r_cnt     <= '0;
                r_arvalid <= 1'b1;
            end else if ((r_state == S_ADDR) && M_AXI_ARREADY) begin
                r_arvalid <= 1'b0;
            end

            if (w_beat) begin
                r_cnt <= r_cnt + 9'd1;
                if (w_last_early || w_last_missing) begin
                    r_err <= 1'b1;
                end
            end

            // A beat with no burst outstanding is a slave protocol violation.
            if (M_AXI_RVALID && (r_state != S_DATA)) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- outputs
    assign S0_AXI_ARREADY = w_s0_arready;
    assign S1_AXI_ARREADY = w_s1_arready;
    assign S0_AXI_RVALID  = w_s0_rvalid;
    assign S1_AXI_RVALID  = w_s1_rvalid;
    assign M_AXI_RREADY   = w_m_rready;

    assign S0_AXI_RID     = M_AXI_RID;
    assign S0_AXI_RDATA   = M_AXI_RDATA;
    assign S0_AXI_RRESP   = M_AXI_RRESP;
    assign S0_AXI_RLAST   = M_AXI_RLAST;
    assign S1_AXI_RID     = M_AXI_RID;
    assign S1_AXI_RDATA   = M_AXI_RDATA;
    assign S1_AXI_RRESP   = M_AXI_RRESP;
    assign S1_AXI_RLAST   = M_AXI_RLAST;

    assign M_AXI_ARVALID  = r_arvalid;
    assign M_AXI_ARID     = r_arid;
    assign M_AXI_ARADDR   = r_araddr;
    assign M_AXI_ARLEN    = r_arlen;

    assign o_grant        = r_grant;
    assign o_busy         = (r_state != S_IDLE);
    assign o_proto_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [1:0]  s0_arid, s0_rid, s0_rresp;
    logic [31:0] s0_araddr, s0_rdata;
    logic [7:0]  s0_arlen;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [1:0]  s1_arid, s1_rid, s1_rresp;
    logic [31:0] s1_araddr, s1_rdata;
    logic [7:0]  s1_arlen;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [1:0]  m_arid, m_rid, m_rresp;
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic        o_grant, o_busy, o_proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    axi_rd_arbiter u_dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .S0_AXI_ARVALID (s0_arvalid),
        .S0_AXI_ARREADY (s0_arready),
        .S0_AXI_ARID    (s0_arid),
        .S0_AXI_ARADDR  (s0_araddr),
        .S0_AXI_ARLEN   (s0_arlen),
        .S0_AXI_RVALID  (s0_rvalid),
        .S0_AXI_RREADY  (s0_rready),
        .S0_AXI_RID     (s0_rid),
        .S0_AXI_RDATA   (s0_rdata),
        .S0_AXI_RRESP   (s0_rresp),
        .S0_AXI_RLAST   (s0_rlast),
        .S1_AXI_ARVALID (s1_arvalid),
        .S1_AXI_ARREADY (s1_arready),
        .S1_AXI_ARID    (s1_arid),
        .S1_AXI_ARADDR  (s1_araddr),
        .S1_AXI_ARLEN   (s1_arlen),
        .S1_AXI_RVALID  (s1_rvalid),
        .S1_AXI_RREADY  (s1_rready),
        .S1_AXI_RID     (s1_rid),
        .S1_AXI_RDATA   (s1_rdata),
        .S1_AXI_RRESP   (s1_rresp),
        .S1_AXI_RLAST   (s1_rlast),
        .M_AXI_ARVALID  (m_arvalid),
        .M_AXI_ARREADY  (m_arready),
        .M_AXI_ARID     (m_arid),
        .M_AXI_ARADDR   (m_araddr),
        .M_AXI_ARLEN    (m_arlen),
        .M_AXI_RVALID   (m_rvalid),
        .M_AXI_RREADY   (m_rready),
        .M_AXI_RID      (m_rid),
        .M_AXI_RDATA    (m_rdata),
        .M_AXI_RRESP    (m_rresp),
        .M_AXI_RLAST    (m_rlast),
        .o_grant        (o_grant),
        .o_busy         (o_busy),
        .o_proto_err    (o_proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-requester AR handshake followed by the slave accepting at once.
    task automatic req(input int m, input logic [1:0] id, input logic [31:0] addr,
                       input logic [7:0] len);
        if (m == 0) begin
            s0_arvalid = 1'b1; s0_arid = id; s0_araddr = addr; s0_arlen = len;
        end else begin
            s1_arvalid = 1'b1; s1_arid = id; s1_araddr = addr; s1_arlen = len;
        end
        #1;
        chk("req_arready", (m == 0) ? s0_arready : s1_arready, 1'b1);
        chk("req_m_arvalid_pre", m_arvalid, 1'b0);
        step();
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        #1;
        chk("req_m_arvalid", m_arvalid, 1'b1);
        chk("req_m_arid", m_arid, id);
        chk("req_m_araddr", m_araddr, addr);
        chk("req_m_arlen", m_arlen, len);
        chk("req_grant", o_grant, m[0]);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        #1;
        chk("req_m_arvalid_drop", m_arvalid, 1'b0);
        chk("req_busy", o_busy, 1'b1);
    endtask

    // One slave beat that must be routed to master m and accepted.
    task automatic beat(input int m, input logic [31:0] data, input logic last);
        m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rid = 2'd1;
        #1;
        chk("beat_rvalid", (m == 0) ? s0_rvalid : s1_rvalid, 1'b1);
        chk("beat_other_rvalid", (m == 0) ? s1_rvalid : s0_rvalid, 1'b0);
        chk("beat_rdata", (m == 0) ? s0_rdata : s1_rdata, data);
        chk("beat_rlast", (m == 0) ? s0_rlast : s1_rlast, last);
        chk("beat_m_rready", m_rready, 1'b1);
        step();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s0_arvalid = 1'b1; s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_rready = 1'b1;
        s1_arvalid = 1'b0; s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_rready = 1'b1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;

        // ---- reset state
        step(); step();
        chk("rst_s0_arready", s0_arready, 1'b0);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_grant", o_grant, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_proto_err, 1'b0);
        s0_arvalid = 1'b0;
        rst = 1'b0;
        step();

        // ---- S0 burst of 4 beats
        req(0, 2'd1, 32'h100, 8'd3);
        for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, i == 3);
        #1;
        chk("t1_busy", o_busy, 1'b0);
        chk("t1_err", o_proto_err, 1'b0);

        // ---- both requesting, single-beat bursts; last grant was 0
        s0_arvalid = 1'b1; s0_arid = 2'd0; s0_araddr = 32'h10; s0_arlen = 8'd0;
        s1_arvalid = 1'b1; s1_arid = 2'd2; s1_araddr = 32'h20; s1_arlen = 8'd0;
        for (int k = 0; k < 4; k++) begin
            logic exp_g;
            exp_g = (k % 2 == 0) ? 1'b1 : 1'b0;
            #1;
            chk("rr_arready_win", exp_g ? s1_arready : s0_arready, 1'b1);
            chk("rr_arready_lose", exp_g ? s0_arready : s1_arready, 1'b0);
            step();
            chk("rr_grant", o_grant, exp_g);
            chk("rr_m_arid", m_arid, exp_g ? 2'd2 : 2'd0);
            m_arready = 1'b1;
            step();
            m_arready = 1'b0;
            beat(exp_g ? 1 : 0, 32'hB0 + k, 1'b1);
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;

        // ---- slave stalls ARREADY for 5 cycles
        s1_arvalid = 1'b1; s1_arid = 2'd3; s1_araddr = 32'h2000; s1_arlen = 8'd1;
        #1;
        chk("st_s1_arready", s1_arready, 1'b1);
        step();
        s1_arvalid = 1'b0;
        s0_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("st_m_arvalid", m_arvalid, 1'b1);
            chk("st_m_araddr", m_araddr, 32'h2000);
            chk("st_m_arid", m_arid, 2'd3);
            chk("st_s0_arready", s0_arready, 1'b0);
            chk("st_s1_arready_hold", s1_arready, 1'b0);
            step();
        end
        s0_arvalid = 1'b0;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        beat(1, 32'hC0, 1'b0);
        beat(1, 32'hC1, 1'b1);
        #1;
        chk("st_busy", o_busy, 1'b0);
        chk("st_err", o_proto_err, 1'b0);

        // ---- S0 backpressure for 3 cycles mid-burst
        req(0, 2'd0, 32'h300, 8'd2);
        beat(0, 32'hD0, 1'b0);
        s0_rready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hD1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_m_rready", m_rready, 1'b0);
            chk("bp_s0_rvalid", s0_rvalid, 1'b1);
            step();
        end
        s0_rready = 1'b1;
        beat(0, 32'hD1, 1'b0);
        beat(0, 32'hD2, 1'b1);
        #1;
        chk("bp_busy", o_busy, 1'b0);
        chk("bp_err", o_proto_err, 1'b0);

        // ---- early RLAST: ARLEN=2, RLAST on beat 1
        req(0, 2'd0, 32'h400, 8'd2);
        beat(0, 32'hE0, 1'b0);
        beat(0, 32'hE1, 1'b1);
        #1;
        chk("early_err", o_proto_err, 1'b1);
        chk("early_busy", o_busy, 1'b0);
        step();
        chk("early_err_sticky", o_proto_err, 1'b1);
        rst = 1'b1;
        #1;
        chk("early_err_clear", o_proto_err, 1'b0);
        rst = 1'b0;
        step();

        // ---- ARLEN=0 with RLAST on beat 1
        req(1, 2'd2, 32'h500, 8'd0);
        beat(1, 32'hF0, 1'b0);
        beat(1, 32'hF1, 1'b1);
        #1;
        chk("late_err", o_proto_err, 1'b1);
        chk("late_busy", o_busy, 1'b0);

        // ---- reset during DATA
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req(0, 2'd1, 32'h600, 8'd3);
        beat(0, 32'h60, 1'b0);
        m_rvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rd_s0_rvalid", s0_rvalid, 1'b0);
        chk("rd_m_rready", m_rready, 1'b0);
        chk("rd_m_arvalid", m_arvalid, 1'b0);
        chk("rd_grant", o_grant, 1'b1);
        chk("rd_busy", o_busy, 1'b0);
        m_rvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
        req(0, 2'd2, 32'h700, 8'd0);
        beat(0, 32'h70, 1'b1);
        #1;
        chk("rd_after_err", o_proto_err, 1'b0);

        // ---- stray slave beat while idle
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        chk("stray_m_rready", m_rready, 1'b0);
        chk("stray_s0_rvalid", s0_rvalid, 1'b0);
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("stray_err", o_proto_err, 1'b1);
        chk("stray_busy", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
